// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command sequencer: opcodes, FSM state
// encoding, receiver configuration reset values and a prescale legality helper.
package uart_cmd_ctrl_pkg;

   localparam logic [7:0] CMD_WR    = 8'hAA;
   localparam logic [7:0] CMD_RD    = 8'hBB;
   localparam logic [7:0] CMD_CFG   = 8'hCC;
   localparam logic [7:0] ERR_REPLY = 8'hEE;

   localparam logic [4:0] PRESCALE_RST    = 5'd8;
   localparam logic       PARITY_EN_RST   = 1'b1;
   localparam logic       PARITY_TYPE_RST = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_ADDR,
      ST_WR_DATA,
      ST_RD_ADDR,
      ST_RD_WAIT,
      ST_TX_SEND,
      ST_CFG_DATA
   } state_e;

   // The receiver only supports x4, x8 and x16 oversampling.
   function automatic logic prescale_ok(input logic [4:0] p);
      return (p == 5'd4) || (p == 5'd8) || (p == 5'd16);
   endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bundle of every non-clock signal around the command sequencer: receiver
// byte stream, register-file strobes, transmitter handshake and receiver config.
// master = the sequencer, slave = the surrounding receiver/register file/transmitter.
interface uart_cmd_ctrl_if #(
   parameter int width      = 8,
   parameter int addr_width = 4
);

   logic [width-1:0]      Rx_P_Data;
   logic                  Rx_Data_valid;
   logic                  Rx_Parity_error;
   logic                  Rx_stop_error;
   logic [addr_width-1:0] RF_Address;
   logic                  RF_WrEn;
   logic [width-1:0]      RF_WrData;
   logic                  RF_RdEn;
   logic [width-1:0]      RF_RdData;
   logic                  RF_RdData_valid;
   logic [width-1:0]      Tx_P_Data;
   logic                  Tx_Data_valid;
   logic                  Tx_ready;
   logic [4:0]            Prescale;
   logic                  Parity_EN;
   logic                  Parity_type;
   logic                  Cmd_abort;

   modport master (
      input  Rx_P_Data, Rx_Data_valid, Rx_Parity_error, Rx_stop_error,
      input  RF_RdData, RF_RdData_valid, Tx_ready,
      output RF_Address, RF_WrEn, RF_WrData, RF_RdEn,
      output Tx_P_Data, Tx_Data_valid,
      output Prescale, Parity_EN, Parity_type, Cmd_abort
   );

   modport slave (
      output Rx_P_Data, Rx_Data_valid, Rx_Parity_error, Rx_stop_error,
      output RF_RdData, RF_RdData_valid, Tx_ready,
      input  RF_Address, RF_WrEn, RF_WrData, RF_RdEn,
      input  Tx_P_Data, Tx_Data_valid,
      input  Prescale, Parity_EN, Parity_type, Cmd_abort
   );

endinterface

// File: rtl/uart_cmd_ctrl_timeout.sv
// Idle-cycle watchdog for the command sequencer. Counts while enabled,
// returns to zero on clear or when disabled, and flags expiry on the
// limit-1 count so the owner can abort on that same cycle.
module uart_cmd_timeout #(
   parameter int limit = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (limit > 2) ? $clog2(limit) : 1;

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign expired = enable && (count_q == CW'(limit - 1));

   // Next count: restart on clear or when not watching, hold once expired.
   always_comb begin
      count_d = count_q;
      if (clear || !enable) begin
         count_d = '0;
      end else if (!expired) begin
         count_d = count_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer between UART receiver, register file and UART transmitter.
// Parses write (0xAA addr data), read (0xBB addr) and config (0xCC cfg)
// commands, returns read data over Tx, and owns the receiver configuration.
// Optional macro UART_CMD_ERR_REPLY_EN: every abort also sends 0xEE over Tx.
module uart_cmd_ctrl
   import uart_cmd_ctrl_pkg::*;
#(
   parameter int width       = 8,
   parameter int addr_width  = 4,
   parameter int timeout_cyc = 4096
) (
   input logic             CLK,
   input logic             Reset,
   uart_cmd_ctrl_if.master bus
);

   state_e                state_q, state_d;
   logic [addr_width-1:0] rf_address_q, rf_address_d;
   logic [width-1:0]      rf_wr_data_q, rf_wr_data_d;
   logic [width-1:0]      tx_data_q, tx_data_d;
   logic                  rf_wr_en_q, rf_wr_en_d;
   logic                  rf_rd_en_q, rf_rd_en_d;
   logic                  tx_valid_q, tx_valid_d;
   logic                  cmd_abort_q, cmd_abort_d;
   logic [4:0]            prescale_q, prescale_d;
   logic                  parity_en_q, parity_en_d;
   logic                  parity_type_q, parity_type_d;

   logic [width-1:0]      rx_byte;
   logic                  rx_err;
   logic                  byte_taken;
   logic                  do_abort;
   logic                  tmo_clear;
   logic                  tmo_enable;
   logic                  tmo_expired;

   assign rx_byte = bus.Rx_P_Data;
   assign rx_err  = bus.Rx_Parity_error | bus.Rx_stop_error;

   assign tmo_enable = (state_q == ST_WR_ADDR) || (state_q == ST_WR_DATA) ||
                       (state_q == ST_RD_ADDR) || (state_q == ST_RD_WAIT) ||
                       (state_q == ST_CFG_DATA);
   assign tmo_clear  = (state_d != state_q) || byte_taken;

   uart_cmd_timeout #(
      .limit(timeout_cyc)
   ) u_timeout (
      .clk    (CLK),
      .rst_n  (Reset),
      .clear  (tmo_clear),
      .enable (tmo_enable),
      .expired(tmo_expired)
   );

   // Next-state and next-output decode; frame errors beat data, data beats timeout.
   always_comb begin
      state_d       = state_q;
      rf_address_d  = rf_address_q;
      rf_wr_data_d  = rf_wr_data_q;
      tx_data_d     = tx_data_q;
      tx_valid_d    = tx_valid_q;
      prescale_d    = prescale_q;
      parity_en_d   = parity_en_q;
      parity_type_d = parity_type_q;
      rf_wr_en_d    = 1'b0;
      rf_rd_en_d    = 1'b0;
      cmd_abort_d   = 1'b0;
      byte_taken    = 1'b0;
      do_abort      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.Rx_Data_valid) begin
               if (rx_byte == width'(CMD_WR)) begin
                  state_d = ST_WR_ADDR;
               end else if (rx_byte == width'(CMD_RD)) begin
                  state_d = ST_RD_ADDR;
               end else if (rx_byte == width'(CMD_CFG)) begin
                  state_d = ST_CFG_DATA;
               end
            end
         end
         ST_WR_ADDR: begin
            if (rx_err) begin
               do_abort = 1'b1;
            end else if (bus.Rx_Data_valid) begin
               byte_taken   = 1'b1;
               rf_address_d = rx_byte[addr_width-1:0];
               state_d      = ST_WR_DATA;
            end else if (tmo_expired) begin
               do_abort = 1'b1;
            end
         end
         ST_WR_DATA: begin
            if (rx_err) begin
               do_abort = 1'b1;
            end else if (bus.Rx_Data_valid) begin
               byte_taken   = 1'b1;
               rf_wr_data_d = rx_byte;
               rf_wr_en_d   = 1'b1;
               state_d      = ST_IDLE;
            end else if (tmo_expired) begin
               do_abort = 1'b1;
            end
         end
         ST_RD_ADDR: begin
            if (rx_err) begin
               do_abort = 1'b1;
            end else if (bus.Rx_Data_valid) begin
               byte_taken   = 1'b1;
               rf_address_d = rx_byte[addr_width-1:0];
               rf_rd_en_d   = 1'b1;
               state_d      = ST_RD_WAIT;
            end else if (tmo_expired) begin
               do_abort = 1'b1;
            end
         end
         ST_RD_WAIT: begin
            if (bus.RF_RdData_valid) begin
               tx_data_d  = bus.RF_RdData;
               tx_valid_d = 1'b1;
               state_d    = ST_TX_SEND;
            end else if (tmo_expired) begin
               do_abort = 1'b1;
            end
         end
         ST_TX_SEND: begin
            if (bus.Tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         ST_CFG_DATA: begin
            if (rx_err) begin
               do_abort = 1'b1;
            end else if (bus.Rx_Data_valid) begin
               byte_taken = 1'b1;
               if (prescale_ok(rx_byte[4:0])) begin
                  parity_en_d   = rx_byte[7];
                  parity_type_d = rx_byte[6];
                  prescale_d    = rx_byte[4:0];
                  state_d       = ST_IDLE;
               end else begin
                  do_abort = 1'b1;
               end
            end else if (tmo_expired) begin
               do_abort = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (do_abort) begin
         cmd_abort_d = 1'b1;
`ifdef UART_CMD_ERR_REPLY_EN
         tx_data_d   = width'(ERR_REPLY);
         tx_valid_d  = 1'b1;
         state_d     = ST_TX_SEND;
`else
         state_d     = ST_IDLE;
`endif
      end
   end

   // State and registered outputs.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q       <= ST_IDLE;
         rf_address_q  <= '0;
         rf_wr_data_q  <= '0;
         tx_data_q     <= '0;
         rf_wr_en_q    <= 1'b0;
         rf_rd_en_q    <= 1'b0;
         tx_valid_q    <= 1'b0;
         cmd_abort_q   <= 1'b0;
         prescale_q    <= PRESCALE_RST;
         parity_en_q   <= PARITY_EN_RST;
         parity_type_q <= PARITY_TYPE_RST;
      end else begin
         state_q       <= state_d;
         rf_address_q  <= rf_address_d;
         rf_wr_data_q  <= rf_wr_data_d;
         tx_data_q     <= tx_data_d;
         rf_wr_en_q    <= rf_wr_en_d;
         rf_rd_en_q    <= rf_rd_en_d;
         tx_valid_q    <= tx_valid_d;
         cmd_abort_q   <= cmd_abort_d;
         prescale_q    <= prescale_d;
         parity_en_q   <= parity_en_d;
         parity_type_q <= parity_type_d;
      end
   end

   assign bus.RF_Address    = rf_address_q;
   assign bus.RF_WrData     = rf_wr_data_q;
   assign bus.RF_WrEn       = rf_wr_en_q;
   assign bus.RF_RdEn       = rf_rd_en_q;
   assign bus.Tx_P_Data     = tx_data_q;
   assign bus.Tx_Data_valid = tx_valid_q;
   assign bus.Cmd_abort     = cmd_abort_q;
   assign bus.Prescale      = prescale_q;
   assign bus.Parity_EN     = parity_en_q;
   assign bus.Parity_type   = parity_type_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl (built with timeout_cyc = 32).
// A command-level model predicts every output each cycle; directed
// scenarios add hand-computed literal expectations.
module tb_uart_cmd_ctrl;

   localparam int TO = 32;

   logic clk = 1'b0;
   logic reset_n;
   int   checks   = 0;
   int   failures = 0;

   uart_cmd_ctrl_if #(.width(8), .addr_width(4)) bus ();

   uart_cmd_ctrl #(
      .width      (8),
      .addr_width (4),
      .timeout_cyc(TO)
   ) dut (
      .CLK  (clk),
      .Reset(reset_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Comparison helper shared by the model checker and the directed checks.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   // Command-level model: which command is being collected, how many bytes of it,
   // whether a read reply is pending or being sent, and idle cycles without progress.
   int         m_kind;
   int         m_idx;
   int         m_stall;
   bit         m_wait;
   bit         m_tx;
   logic [3:0] e_addr;
   logic [7:0] e_wdata;
   logic [7:0] e_txd;
   logic [4:0] e_pre;
   bit         e_wren, e_rden, e_txv, e_abort, e_pen, e_ptype;

   task model_reset();
      m_kind = 0; m_idx = 0; m_stall = 0; m_wait = 0; m_tx = 0;
      e_addr = 4'h0; e_wdata = 8'h00; e_txd = 8'h00;
      e_pre = 5'd8; e_pen = 1'b1; e_ptype = 1'b0;
      e_wren = 0; e_rden = 0; e_txv = 0; e_abort = 0;
   endtask

   task model_abort();
      e_abort = 1;
      m_wait  = 0;
      m_stall = 0;
`ifdef UART_CMD_ERR_REPLY_EN
      e_txd = 8'hEE;
      e_txv = 1;
      m_tx  = 1;
`else
      m_kind = 0;
`endif
   endtask

   task model_byte(input logic [7:0] b);
      case (m_kind)
         1: begin
            if (m_idx == 0) begin
               e_addr = b[3:0];
               m_idx  = 1;
            end else begin
               e_wdata = b;
               e_wren  = 1;
               m_kind  = 0;
            end
         end
         2: begin
            e_addr = b[3:0];
            e_rden = 1;
            m_wait = 1;
         end
         default: begin
            if (b[4:0] == 5'd4 || b[4:0] == 5'd8 || b[4:0] == 5'd16) begin
               e_pre   = b[4:0];
               e_pen   = b[7];
               e_ptype = b[6];
               m_kind  = 0;
            end else begin
               model_abort();
            end
         end
      endcase
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            model_reset();
         end else begin
            e_wren = 0; e_rden = 0; e_abort = 0;
            if (m_tx) begin
               if (bus.Tx_ready) begin
                  e_txv = 0; m_tx = 0; m_kind = 0;
               end
            end else if (m_wait) begin
               if (bus.RF_RdData_valid) begin
                  e_txd = bus.RF_RdData; e_txv = 1; m_tx = 1; m_wait = 0;
               end else begin
                  m_stall++;
                  if (m_stall == TO) model_abort();
               end
            end else if (m_kind != 0) begin
               if (bus.Rx_Parity_error || bus.Rx_stop_error) begin
                  model_abort();
               end else if (bus.Rx_Data_valid) begin
                  m_stall = 0;
                  model_byte(bus.Rx_P_Data);
               end else begin
                  m_stall++;
                  if (m_stall == TO) model_abort();
               end
            end else if (bus.Rx_Data_valid) begin
               case (bus.Rx_P_Data)
                  8'hAA:   m_kind = 1;
                  8'hBB:   m_kind = 2;
                  8'hCC:   m_kind = 3;
                  default: m_kind = 0;
               endcase
               m_idx = 0; m_stall = 0;
            end
         end
      end
   end

   // Model comparison on every falling edge while out of reset.
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1) begin
            checkOutput("model_rf_address",  32'(bus.RF_Address),    32'(e_addr));
            checkOutput("model_rf_wrdata",   32'(bus.RF_WrData),     32'(e_wdata));
            checkOutput("model_rf_wren",     32'(bus.RF_WrEn),       32'(e_wren));
            checkOutput("model_rf_rden",     32'(bus.RF_RdEn),       32'(e_rden));
            checkOutput("model_tx_data",     32'(bus.Tx_P_Data),     32'(e_txd));
            checkOutput("model_tx_valid",    32'(bus.Tx_Data_valid), 32'(e_txv));
            checkOutput("model_cmd_abort",   32'(bus.Cmd_abort),     32'(e_abort));
            checkOutput("model_prescale",    32'(bus.Prescale),      32'(e_pre));
            checkOutput("model_parity_en",   32'(bus.Parity_EN),     32'(e_pen));
            checkOutput("model_parity_type", 32'(bus.Parity_type),   32'(e_ptype));
         end
      end
   end

   // Event monitor sampled just after each rising edge.
   int         cyc = 0, wr_count = 0, rd_count = 0, abort_count = 0, tx_cycles = 0;
   int         rd_cyc = 0, abort_cyc = 0;
   logic [3:0] last_wr_addr = 4'h0, last_rd_addr = 4'h0;
   logic [7:0] last_wr_data = 8'h00;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.RF_WrEn) begin
            wr_count++; last_wr_addr = bus.RF_Address; last_wr_data = bus.RF_WrData;
         end
         if (bus.RF_RdEn) begin
            rd_count++; rd_cyc = cyc; last_rd_addr = bus.RF_Address;
         end
         if (bus.Cmd_abort) begin
            abort_count++; abort_cyc = cyc;
         end
         if (bus.Tx_Data_valid) tx_cycles++;
      end
   end

   // One receiver byte, optionally with a coincident stop error.
   task applyStimulus(input logic [7:0] b, input logic err);
      repeat (2) @(negedge clk);
      bus.Rx_P_Data     = b;
      bus.Rx_Data_valid = 1'b1;
      bus.Rx_stop_error = err;
      @(negedge clk);
      bus.Rx_Data_valid = 1'b0;
      bus.Rx_stop_error = 1'b0;
   endtask

   // After an abort: either the 0xEE reply is handshaken out, or Tx stays idle.
   task drain_reply();
`ifdef UART_CMD_ERR_REPLY_EN
      int n;
      n = 0;
      while (!bus.Tx_Data_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("err_reply_valid", 32'(bus.Tx_Data_valid), 32'h1);
      checkOutput("err_reply_byte",  32'(bus.Tx_P_Data),     32'hEE);
      bus.Tx_ready = 1'b1;
      @(negedge clk);
      bus.Tx_ready = 1'b0;
      checkOutput("err_reply_dropped", 32'(bus.Tx_Data_valid), 32'h0);
`else
      checkOutput("abort_no_tx", 32'(bus.Tx_Data_valid), 32'h0);
`endif
   endtask

   // Wait (bounded) for the read strobe count to advance, then return data after a delay.
   task respond_read(input int r0, input logic [7:0] data);
      int n;
      n = 0;
      while (rd_count == r0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("read_strobe_seen", 32'(rd_count - r0), 32'h1);
      repeat (2) @(negedge clk);
      bus.RF_RdData       = data;
      bus.RF_RdData_valid = 1'b1;
      @(negedge clk);
      bus.RF_RdData_valid = 1'b0;
      n = 0;
      while (!bus.Tx_Data_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("read_tx_valid", 32'(bus.Tx_Data_valid), 32'h1);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int w0, r0, a0, t0;
      bus.Rx_P_Data = 8'h00; bus.Rx_Data_valid = 1'b0;
      bus.Rx_Parity_error = 1'b0; bus.Rx_stop_error = 1'b0;
      bus.RF_RdData = 8'h00; bus.RF_RdData_valid = 1'b0; bus.Tx_ready = 1'b0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_prescale",    32'(bus.Prescale),      32'd8);
      checkOutput("reset_parity_en",   32'(bus.Parity_EN),     32'h1);
      checkOutput("reset_parity_type", 32'(bus.Parity_type),   32'h0);
      checkOutput("reset_tx_valid",    32'(bus.Tx_Data_valid), 32'h0);
      checkOutput("reset_wren",        32'(bus.RF_WrEn),       32'h0);
      checkOutput("reset_abort",       32'(bus.Cmd_abort),     32'h0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] write command");
      w0 = wr_count; t0 = tx_cycles;
      applyStimulus(8'hAA, 1'b0);
      applyStimulus(8'h05, 1'b0);
      applyStimulus(8'h3C, 1'b0);
      @(negedge clk);
      checkOutput("write_strobe_count", 32'(wr_count - w0),  32'h1);
      checkOutput("write_address",      32'(last_wr_addr),   32'h5);
      checkOutput("write_data",         32'(last_wr_data),   32'h3C);
      checkOutput("write_no_tx",        32'(tx_cycles - t0), 32'h0);

      $display("[TB] read command with Tx backpressure");
      r0 = rd_count;
      applyStimulus(8'hBB, 1'b0);
      applyStimulus(8'h02, 1'b0);
      respond_read(r0, 8'h77);
      checkOutput("read_address", 32'(last_rd_addr), 32'h2);
      for (int i = 0; i < 10; i++) begin
         checkOutput("read_tx_hold_valid", 32'(bus.Tx_Data_valid), 32'h1);
         checkOutput("read_tx_hold_data",  32'(bus.Tx_P_Data),     32'h77);
         @(negedge clk);
      end
      bus.Tx_ready = 1'b1;
      @(negedge clk);
      bus.Tx_ready = 1'b0;
      checkOutput("read_tx_dropped", 32'(bus.Tx_Data_valid), 32'h0);

      $display("[TB] config commands");
      applyStimulus(8'hCC, 1'b0);
      applyStimulus(8'h90, 1'b0);
      @(negedge clk);
      checkOutput("cfg_prescale16",  32'(bus.Prescale),    32'd16);
      checkOutput("cfg_parity_en1",  32'(bus.Parity_EN),   32'h1);
      checkOutput("cfg_parity_typ0", 32'(bus.Parity_type), 32'h0);
      a0 = abort_count;
      applyStimulus(8'hCC, 1'b0);
      applyStimulus(8'h0A, 1'b0);
      @(negedge clk);
      checkOutput("cfg_bad_abort",     32'(abort_count - a0), 32'h1);
      checkOutput("cfg_bad_unchanged", 32'(bus.Prescale),     32'd16);
      drain_reply();
      applyStimulus(8'hCC, 1'b0);
      applyStimulus(8'h44, 1'b0);
      @(negedge clk);
      checkOutput("cfg_prescale4",   32'(bus.Prescale),    32'd4);
      checkOutput("cfg_parity_en0",  32'(bus.Parity_EN),   32'h0);
      checkOutput("cfg_parity_typ1", 32'(bus.Parity_type), 32'h1);

      $display("[TB] stop error during write data");
      w0 = wr_count; a0 = abort_count;
      applyStimulus(8'hAA, 1'b0);
      applyStimulus(8'h05, 1'b0);
      applyStimulus(8'h3C, 1'b1);
      @(negedge clk);
      checkOutput("err_no_write", 32'(wr_count - w0),    32'h0);
      checkOutput("err_abort",    32'(abort_count - a0), 32'h1);
      drain_reply();
      applyStimulus(8'hAA, 1'b0);
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h11, 1'b0);
      @(negedge clk);
      checkOutput("err_next_write",      32'(wr_count - w0), 32'h1);
      checkOutput("err_next_write_addr", 32'(last_wr_addr),  32'h1);
      checkOutput("err_next_write_data", 32'(last_wr_data),  32'h11);

      $display("[TB] read timeout");
      r0 = rd_count; a0 = abort_count;
      applyStimulus(8'hBB, 1'b0);
      applyStimulus(8'h03, 1'b0);
      repeat (40) @(negedge clk);
      checkOutput("timeout_read_strobe", 32'(rd_count - r0),     32'h1);
      checkOutput("timeout_abort",       32'(abort_count - a0),  32'h1);
      checkOutput("timeout_latency",     32'(abort_cyc - rd_cyc), 32'(TO));
      drain_reply();

      $display("[TB] reset during reply");
      r0 = rd_count;
      applyStimulus(8'hBB, 1'b0);
      applyStimulus(8'h07, 1'b0);
      respond_read(r0, 8'h5A);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("rst_tx_valid",    32'(bus.Tx_Data_valid), 32'h0);
      checkOutput("rst_prescale",    32'(bus.Prescale),      32'd8);
      checkOutput("rst_parity_en",   32'(bus.Parity_EN),     32'h1);
      checkOutput("rst_parity_type", 32'(bus.Parity_type),   32'h0);
      checkOutput("rst_rf_address",  32'(bus.RF_Address),    32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command sequencer between the UART receiver and the system register file and UART transmitter. It parses byte streams from the receiver's P_Data/Data_valid into write, read and config commands, and drives register-file strobes. It returns read data through the transmitter with a valid/ready handshake. It also owns the receiver's runtime configuration (Prescale, Parity_EN, Parity_type).

Parameters:
width, 8, data byte width (receiver P_Data, register data)
addr_width, 4, register-file address width
timeout_cyc, 4096, max idle cycles between command bytes, or while waiting for read data, before abort

Ports:
CLK  input  1  system clock
Reset  input  1  asynchronous active-low reset
Rx_P_Data  input  width  byte from receiver
Rx_Data_valid  input  1  one-cycle pulse, Rx_P_Data valid
Rx_Parity_error  input  1  one-cycle pulse, parity error on current frame
Rx_stop_error  input  1  one-cycle pulse, stop error on current frame
RF_Address  output  addr_width  register-file address
RF_WrEn  output  1  one-cycle write strobe
RF_WrData  output  width  write data
RF_RdEn  output  1  one-cycle read strobe
RF_RdData  input  width  read data
RF_RdData_valid  input  1  read data valid pulse, 1..N cycles after RF_RdEn
Tx_P_Data  output  width  byte to transmitter
Tx_Data_valid  output  1  transmit request
Tx_ready  input  1  transmitter accepts byte when high with Tx_Data_valid
Prescale  output  5  receiver oversampling config
Parity_EN  output  1  receiver parity enable
Parity_type  output  1  0 even, 1 odd
Cmd_abort  output  1  one-cycle pulse on command abort

Behaviour:
- Reset (Reset low, asynchronous): state IDLE; all strobes, Tx_Data_valid and Cmd_abort 0; RF_Address, RF_WrData and Tx_P_Data 0; Prescale 5'd8, Parity_EN 1, Parity_type 0; timeout counter 0.
- Command opcodes (first byte): 0xAA write, 0xBB read, 0xCC config. Any other byte in IDLE is ignored. No abort is raised for it.
- States and transitions:
  - IDLE: on 0xAA → WR_ADDR; 0xBB → RD_ADDR; 0xCC → CFG_DATA.
  - WR_ADDR: on byte, latch RF_Address = byte[addr_width-1:0] → WR_DATA.
  - WR_DATA: on byte, RF_WrData = byte and RF_WrEn = 1 for exactly the next cycle → IDLE.
  - RD_ADDR: on byte, latch address; RF_RdEn pulses next cycle → RD_WAIT.
  - RD_WAIT: on RF_RdData_valid, Tx_P_Data = RF_RdData and Tx_Data_valid = 1 → TX_SEND.
  - TX_SEND: hold Tx_Data_valid and Tx_P_Data stable until a cycle with Tx_ready = 1. Drop valid the following cycle → IDLE.
  - CFG_DATA: on byte b, Parity_EN = b[7], Parity_type = b[6], Prescale = b[4:0]. This applies only if b[4:0] is 4, 8 or 16. Otherwise the config is unchanged and Cmd_abort pulses. Either way → IDLE.
- Config outputs update the cycle after the accepting Rx_Data_valid and are held stable otherwise.
- Errors: Rx_Parity_error or Rx_stop_error in WR_ADDR, WR_DATA, RD_ADDR or CFG_DATA → Cmd_abort pulse → IDLE. No RF strobe is issued. The errors are ignored in IDLE, RD_WAIT and TX_SEND.
- Simultaneous Rx_Data_valid and an error pulse in the same cycle: the error wins and the byte is discarded.
- Timeout: the counter resets on each state change and on each accepted byte. It counts in every non-IDLE state except TX_SEND. At timeout_cyc-1 → Cmd_abort pulse → IDLE.
- TX_SEND never times out, because the transmitter backpressure is legitimate.
- Rx_Data_valid arriving in RD_WAIT or TX_SEND is dropped. No queueing.
- RF_WrEn and RF_RdEn are never high simultaneously and never high for two consecutive cycles.

Optional Feature:
- Macro: UART_CMD_ERR_REPLY_EN.
- Defined: every Cmd_abort additionally queues reply byte 0xEE on Tx. The controller goes to TX_SEND with Tx_P_Data = 0xEE and uses the same handshake before returning to IDLE.
- Undefined: aborts only pulse Cmd_abort; Tx is untouched.

Decomposition:
- Shared package: opcode constants (CMD_WR 8'hAA, CMD_RD 8'hBB, CMD_CFG 8'hCC, ERR_REPLY 8'hEE), state encoding, reset config constants (PRESCALE_RST 5'd8, PARITY_EN_RST, PARITY_TYPE_RST).
- One natural sub-module: uart_cmd_timeout (loadable counter with clear/enable, expired flag) instantiated by the FSM.

Test Plan:
- Write: bytes 0xAA, 0x05, 0x3C → one-cycle RF_WrEn with RF_Address 5 and RF_WrData 0x3C. No Tx activity.
- Read: bytes 0xBB, 0x02; RF returns 0x77 three cycles after RF_RdEn; Tx_ready is low for 10 cycles then high → Tx_Data_valid held with 0x77 for the whole wait, dropped the cycle after the handshake.
- Config: bytes 0xCC, 0x90 → Prescale 16, Parity_EN 1, Parity_type 0. Then 0xCC, 0x0A → config unchanged and Cmd_abort pulses.
- Error abort: 0xAA, 0x05, then Rx_stop_error pulse coincident with Rx_Data_valid of data → no RF_WrEn, Cmd_abort pulse, state IDLE. A following 0xAA, 0x01, 0x11 writes normally.
- Timeout: 0xBB, 0x03 with RF_RdData_valid never asserted → Cmd_abort exactly timeout_cyc cycles after RF_RdEn (test with timeout_cyc=32). With UART_CMD_ERR_REPLY_EN, 0xEE is transmitted.
- Reset mid-read: assert Reset during TX_SEND → Tx_Data_valid 0 immediately and config back to 8/1/0.
